// File: rtl/fp_ncomp_dispatch_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_ncomp_dispatch_if : issue/core/retire handshake bundle for the dispatcher
// Revision: 1.0
// ---------------------------------------------------------------------------
interface fp_ncomp_dispatch_if #(
  parameter int LANES         = 1,
  parameter int TAGW          = 2,
  parameter int UUIDW         = 8,
  parameter int INST_FPU_BITS = 4,
  parameter int INST_FRM_BITS = 3
);
  logic                     req_valid;
  logic                     req_ready;
  logic [UUIDW-1:0]         req_uuid;
  logic [INST_FPU_BITS-1:0] req_op_type;
  logic [INST_FRM_BITS-1:0] req_frm;
  logic [LANES*32-1:0]      req_dataa;
  logic [LANES*32-1:0]      req_datab;

  logic                     core_valid_in;
  logic                     core_ready_in;
  logic [TAGW-1:0]          core_tag_in;
  logic [INST_FPU_BITS-1:0] core_op_type;
  logic [INST_FRM_BITS-1:0] core_frm;
  logic [LANES*32-1:0]      core_dataa;
  logic [LANES*32-1:0]      core_datab;

  logic                     core_valid_out;
  logic                     core_ready_out;
  logic [TAGW-1:0]          core_tag_out;
  logic [LANES*32-1:0]      core_result;
  logic                     core_has_fflags;
  logic [LANES*5-1:0]       core_fflags;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [UUIDW-1:0]         rsp_uuid;
  logic [LANES*32-1:0]      rsp_result;
  logic                     rsp_has_fflags;
  logic [4:0]               rsp_fflags;
  logic                     tag_err;

  modport slave (
    input  req_valid, req_uuid, req_op_type, req_frm, req_dataa, req_datab,
    output req_ready,
    output core_valid_in, core_tag_in, core_op_type, core_frm, core_dataa, core_datab,
    input  core_ready_in,
    input  core_valid_out, core_tag_out, core_result, core_has_fflags, core_fflags,
    output core_ready_out,
    output rsp_valid, rsp_uuid, rsp_result, rsp_has_fflags, rsp_fflags, tag_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_uuid, req_op_type, req_frm, req_dataa, req_datab,
    input  req_ready,
    input  core_valid_in, core_tag_in, core_op_type, core_frm, core_dataa, core_datab,
    output core_ready_in,
    output core_valid_out, core_tag_out, core_result, core_has_fflags, core_fflags,
    input  core_ready_out,
    input  rsp_valid, rsp_uuid, rsp_result, rsp_has_fflags, rsp_fflags, tag_err,
    output rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/fp_ncomp_dispatch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_ncomp_dispatch : tag-allocating requester for the FPU non-comp core,
//                     retiring out-of-order completions in program order
// Revision: 1.0
// ---------------------------------------------------------------------------
module fp_ncomp_dispatch #(
  parameter int LANES         = 1,
  parameter int TAGW          = 2,
  parameter int UUIDW         = 8,
  parameter int INST_FPU_BITS = 4,
  parameter int INST_FRM_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_ncomp_dispatch_if.slave   bus
);
  localparam int              DEPTH      = 1 << TAGW;
  localparam logic [TAGW:0]   FULL_COUNT = DEPTH[TAGW:0];

  logic [DEPTH-1:0]    pending;
  logic [DEPTH-1:0]    done;
  logic [DEPTH-1:0]    ent_has_fflags;
  logic [UUIDW-1:0]    ent_uuid   [DEPTH];
  logic [LANES*32-1:0] ent_result [DEPTH];
  logic [LANES*5-1:0]  ent_fflags [DEPTH];

  logic [TAGW-1:0]     head;
  logic [TAGW-1:0]     tail;
  logic [TAGW:0]       count;
  logic                tag_err_q;
  logic                ready_out_q;

  logic                full;
  logic                issue_fire;
  logic                retire_fire;
  logic                cpl_seen;
  logic                cpl_ok;
  logic [4:0]          lane_or;

  assign full        = (count == FULL_COUNT);
  assign issue_fire  = bus.req_valid & bus.core_ready_in & ~full;
  assign retire_fire = done[head] & bus.rsp_ready;
  assign cpl_seen    = bus.core_valid_out & ready_out_q;
  assign cpl_ok      = cpl_seen & pending[bus.core_tag_out] & ~done[bus.core_tag_out];

  // Issue path is a pure pass-through gated only by reorder-buffer space.
  assign bus.req_ready     = bus.core_ready_in & ~full;
  assign bus.core_valid_in = bus.req_valid & ~full;
  assign bus.core_tag_in   = tail;
  assign bus.core_op_type  = bus.req_op_type;
  assign bus.core_frm      = bus.req_frm;
  assign bus.core_dataa    = bus.req_dataa;
  assign bus.core_datab    = bus.req_datab;
  assign bus.core_ready_out = ready_out_q;

  // Retire, issue and completion always hit distinct entries, so their
  // writes to pending/done never conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      done        <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      tag_err_q   <= 1'b0;
      ready_out_q <= 1'b0;
    end else begin
      ready_out_q <= 1'b1;
      if (retire_fire) begin
        pending[head] <= 1'b0;
        done[head]    <= 1'b0;
        head          <= head + 1'b1;
      end
      if (issue_fire) begin
        pending[tail] <= 1'b1;
        done[tail]    <= 1'b0;
        tail          <= tail + 1'b1;
      end
      if (cpl_ok) begin
        done[bus.core_tag_out] <= 1'b1;
      end
      if (cpl_seen && !cpl_ok) begin
        tag_err_q <= 1'b1;
      end
      case ({issue_fire, retire_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue_fire) begin
      ent_uuid[tail] <= bus.req_uuid;
    end
    if (cpl_ok) begin
      ent_result[bus.core_tag_out]     <= bus.core_result;
      ent_has_fflags[bus.core_tag_out] <= bus.core_has_fflags;
      ent_fflags[bus.core_tag_out]     <= bus.core_fflags;
    end
  end

  always_comb begin
    lane_or = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_or = lane_or | ent_fflags[head][l*5 +: 5];
    end
  end

  assign bus.rsp_valid      = done[head];
  assign bus.rsp_uuid       = ent_uuid[head];
  assign bus.rsp_result     = ent_result[head];
  assign bus.rsp_has_fflags = ent_has_fflags[head];
  assign bus.rsp_fflags     = ent_has_fflags[head] ? lane_or : 5'd0;
  assign bus.tag_err        = tag_err_q;

endmodule
`default_nettype wire
